demap_symbol_sequencer: RTL and testbench

//  Front-end scheduler for the Wi-Fi demap chain. Accepts the equalised 64-bin

---
 rtl/demap_symbol_sequencer_pkg.sv | 52 +++++
 rtl/demap_symbol_sequencer_if.sv | 36 +++
 rtl/demap_symbol_sequencer_bin_classifier.sv | 23 ++
 rtl/demap_symbol_sequencer.sv | 141 ++++++++++++++
 tb/tb_demap_symbol_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demap_symbol_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// demap_symbol_sequencer_pkg
// Shared constants and types for the Wi-Fi demap front-end sequencer:
//   - FFT geometry (64 bins, 48 data bins per OFDM symbol)
//   - pilot bin list and null bin bounds (DC bin and the guard band 27..37)
//   - sequencer FSM state encoding and bin class encoding
//   - bin classification helper functions
// ----------------------------------------------------------------------------
package demap_symbol_sequencer_pkg;

   localparam int N_FFT   = 64;
   localparam int N_DATA  = 48;
   localparam int N_PILOT = 4;

   localparam logic [5:0] PILOT_IDX [N_PILOT] = '{6'd7, 6'd21, 6'd43, 6'd57};

   // Null bins are the DC bin plus the contiguous guard band around Nyquist.
   localparam logic [5:0] NULL_DC = 6'd0;
   localparam logic [5:0] NULL_LO = 6'd27;
   localparam logic [5:0] NULL_HI = 6'd37;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      BIN_NULL  = 2'd0,
      BIN_PILOT = 2'd1,
      BIN_DATA  = 2'd2
   } bin_class_t;

   function automatic logic is_null_bin(input logic [5:0] idx);
      return (idx == NULL_DC) || ((idx >= NULL_LO) && (idx <= NULL_HI));
   endfunction

   function automatic logic is_pilot_bin(input logic [5:0] idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_PILOT; i++) begin
         if (idx == PILOT_IDX[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic is_data_bin(input logic [5:0] idx);
      return !is_null_bin(idx) && !is_pilot_bin(idx);
   endfunction

endpackage

// File: rtl/demap_symbol_sequencer_if.sv
// ----------------------------------------------------------------------------
// demap_symbol_sequencer_if
// Bin stream bundle around the sequencer.
//   in_valid/in_ready/in_real/in_imag : upstream equalised bin stream
//   stop_flag                         : downstream stall request
//   out_valid/out_real/out_imag       : forwarded data-bin strobe and sample
//   special_index                     : FFT bin index of the forwarded sample
//   last_symbol                       : forwarded sample belongs to final symbol
// Modports:
//   master : the environment (bin source, stack controller)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface demap_symbol_sequencer_if #(
   parameter int DW = 12
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_imag;
   logic                 stop_flag;
   logic                 out_valid;
   logic signed [DW-1:0] out_real;
   logic signed [DW-1:0] out_imag;
   logic [5:0]           special_index;
   logic                 last_symbol;

   modport master (
      output in_valid, in_real, in_imag, stop_flag,
      input  in_ready, out_valid, out_real, out_imag, special_index, last_symbol
   );

   modport slave (
      input  in_valid, in_real, in_imag, stop_flag,
      output in_ready, out_valid, out_real, out_imag, special_index, last_symbol
   );
endinterface

// File: rtl/demap_symbol_sequencer_bin_classifier.sv
// ----------------------------------------------------------------------------
// demap_bin_classifier
// Combinational FFT-bin classifier.
//   idx : FFT bin index 0..63 (FFT order)
//   cls : BIN_NULL, BIN_PILOT or BIN_DATA
// ----------------------------------------------------------------------------
module demap_bin_classifier
   import demap_symbol_sequencer_pkg::*;
(
   input  logic [5:0] idx,
   output bin_class_t cls
);

   always_comb begin
      cls = BIN_DATA;
      if (is_null_bin(idx)) begin
         cls = BIN_NULL;
      end else if (is_pilot_bin(idx)) begin
         cls = BIN_PILOT;
      end
   end

endmodule

// File: rtl/demap_symbol_sequencer.sv
// ----------------------------------------------------------------------------
// demap_symbol_sequencer
// Front-end scheduler for the Wi-Fi demap chain. Accepts one equalised bin
// per cycle, counts bins and OFDM symbols, drops null/pilot bins and forwards
// the 48 data bins per symbol with their bin index and a last-symbol flag.
// Ports:
//   clk, reset   : demap clock, asynchronous active-high reset
//   start        : 1-cycle pulse starting a packet (ignored outside IDLE)
//   num_symbols  : data symbols in the packet, sampled on start
//   busy         : high in RUN and FLUSH
//   done         : 1-cycle pulse when the packet is complete
//   bus          : bin stream bundle (slave side), see the interface file
// ----------------------------------------------------------------------------
module demap_symbol_sequencer
   import demap_symbol_sequencer_pkg::*;
#(
   parameter int DW    = 12,
   parameter int SYM_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [SYM_W-1:0]   num_symbols,
   output logic               busy,
   output logic               done,
   demap_symbol_sequencer_if.slave bus
);

   state_t               state_q, state_d;
   logic [5:0]           bin_cnt_q, bin_cnt_d;
   logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
   logic [SYM_W-1:0]     num_sym_q, num_sym_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [DW-1:0] out_real_q, out_real_d;
   logic signed [DW-1:0] out_imag_q, out_imag_d;
   logic [5:0]           index_q, index_d;
   logic                 last_q, last_d;

   bin_class_t           bin_cls;
   logic                 in_ready;
   logic                 xfer;
   logic                 final_sym;
   logic                 last_bin;

   demap_bin_classifier u_classifier (
      .idx (bin_cnt_q),
      .cls (bin_cls)
   );

   // Ready only depends on state and the stall request, so a stall takes
   // effect in the same cycle it is raised.
   assign in_ready  = (state_q == ST_RUN) && !bus.stop_flag;
   assign xfer      = bus.in_valid && in_ready;
   assign final_sym = (sym_cnt_q == (num_sym_q - SYM_W'(1)));
   assign last_bin  = (bin_cnt_q == 6'(N_FFT - 1));

   always_comb begin
      state_d     = state_q;
      bin_cnt_d   = bin_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      num_sym_d   = num_sym_q;
      out_valid_d = 1'b0;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      index_d     = index_q;
      last_d      = last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_sym_d = num_symbols;
               bin_cnt_d = '0;
               sym_cnt_d = '0;
               state_d   = (num_symbols != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               // bin_cnt wraps 63->0 by width; sym_cnt advances on that wrap.
               bin_cnt_d = bin_cnt_q + 6'd1;
               if (last_bin) begin
                  sym_cnt_d = sym_cnt_q + SYM_W'(1);
                  if (final_sym) state_d = ST_FLUSH;
               end
               if (bin_cls == BIN_DATA) begin
                  out_valid_d = 1'b1;
                  out_real_d  = bus.in_real;
                  out_imag_d  = bus.in_imag;
                  index_d     = bin_cnt_q;
                  last_d      = final_sym;
               end
            end
         end
         // One cycle for the final registered beat to drain.
         ST_FLUSH: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bin_cnt_q   <= '0;
         sym_cnt_q   <= '0;
         num_sym_q   <= '0;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         index_q     <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_cnt_q   <= bin_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         num_sym_q   <= num_sym_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         index_q     <= index_d;
         last_q      <= last_d;
      end
   end

   assign busy              = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done              = (state_q == ST_DONE);
   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_real      = out_real_q;
   assign bus.out_imag      = out_imag_q;
   assign bus.special_index = index_q;
   assign bus.last_symbol   = last_q;

endmodule

// File: tb/tb_demap_symbol_sequencer.sv
module tb_demap_symbol_sequencer;
   localparam int DW    = 12;
   localparam int SYM_W = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [SYM_W-1:0] num_symbols;
   logic             busy;
   logic             done;

   demap_symbol_sequencer_if #(.DW(DW)) ifc ();

   demap_symbol_sequencer #(.DW(DW), .SYM_W(SYM_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_symbols (num_symbols),
      .busy        (busy),
      .done        (done),
      .bus         (ifc.slave)
   );

   always #20 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int idx;
      int re;
      int im;
      int last;
   } beat_t;

   beat_t got_q[$];
   beat_t mon_b;

   always @(negedge clk) begin
      if (ifc.out_valid === 1'b1) begin
         mon_b.idx  = int'(ifc.special_index);
         mon_b.re   = int'(ifc.out_real);
         mon_b.im   = int'(ifc.out_imag);
         mon_b.last = int'(ifc.last_symbol);
         got_q.push_back(mon_b);
      end
   end

   // Reference bin map written out by hand from the Wi-Fi 64-bin layout.
   function automatic bit tb_is_data(input int b);
      if (b == 0) return 1'b0;
      if (b >= 27 && b <= 37) return 1'b0;
      if (b == 7 || b == 21 || b == 43 || b == 57) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_beats(input string t, input int n);
      int k;
      int nlast;
      k = 0;
      nlast = 0;
      chk({t, "_beats"}, got_q.size(), 48 * n);
      for (int s = 0; s < n; s++) begin
         for (int b = 0; b < 64; b++) begin
            if (tb_is_data(b)) begin
               if (k < got_q.size()) begin
                  chk({t, "_idx"},  got_q[k].idx,  b);
                  chk({t, "_re"},   got_q[k].re,   b);
                  chk({t, "_im"},   got_q[k].im,   s);
                  chk({t, "_last"}, got_q[k].last, (s == n - 1) ? 1 : 0);
                  nlast += got_q[k].last;
               end
               k++;
            end
         end
      end
      chk({t, "_last_cnt"}, nlast, 48);
   endtask

   task automatic start_pkt(input int n);
      @(negedge clk);
      start       = 1'b1;
      num_symbols = SYM_W'(n);
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic send(input int n, input int stop_bin, input bit rand_v,
                       input int abort_sym, input int abort_bin,
                       output int rdy_low, output int rdy_bad, output bit aborted);
      int sym;
      int bin;
      int guard;
      int stall;
      bit stalled;
      sym = 0; bin = 0; guard = 0; stall = 0; stalled = 1'b0;
      rdy_low = 0; rdy_bad = 0; aborted = 1'b0;
      while (sym < n && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (sym == abort_sym && bin == abort_bin) begin
            aborted = 1'b1;
            break;
         end
         ifc.in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
         ifc.in_real  = DW'(bin);
         ifc.in_imag  = DW'(sym);
         if (stall > 0) begin
            ifc.stop_flag = 1'b1;
            stall--;
         end else if (!stalled && sym == 0 && bin == stop_bin) begin
            ifc.stop_flag = 1'b1;
            stall   = 9;
            stalled = 1'b1;
         end else begin
            ifc.stop_flag = 1'b0;
         end
         #1;
         if (ifc.in_ready !== !ifc.stop_flag) rdy_bad++;
         if (ifc.in_ready !== 1'b1) rdy_low++;
         if (ifc.in_valid && ifc.in_ready) begin
            bin++;
            if (bin == 64) begin
               bin = 0;
               sym++;
            end
         end
      end
      if (!aborted) chk("send_progress", sym, n);
   endtask

   // Counts negedges (1-based) after the final transfer's edge until done.
   task automatic wait_done(output int done_at, output int done_cnt,
                            output int busy_cnt, output int rdy_cnt);
      done_at = -1; done_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            ifc.in_valid  = 1'b0;
            ifc.stop_flag = 1'b0;
            start         = 1'b0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (busy === 1'b1) busy_cnt++;
         if (ifc.in_ready === 1'b1) rdy_cnt++;
      end
   endtask

   task automatic run_basic(input string t, input int n, input int stop_bin,
                            input bit rand_v, input int exp_low);
      int rl, rb, da, dc, bc, rc;
      bit ab;
      got_q.delete();
      start_pkt(n);
      send(n, stop_bin, rand_v, -1, -1, rl, rb, ab);
      wait_done(da, dc, bc, rc);
      chk({t, "_done_at"},  da, 2);
      chk({t, "_done_cnt"}, dc, 1);
      chk({t, "_busy_cnt"}, bc, 1);
      chk({t, "_rdy_bad"},  rb, 0);
      chk({t, "_rdy_low"},  rl, exp_low);
      chk({t, "_last_idle"}, ifc.last_symbol, 0);
      check_beats(t, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout got=%0t want=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int rl, rb, da, dc, bc, rc;
      bit ab;
      reset         = 1'b1;
      start         = 1'b0;
      num_symbols   = '0;
      ifc.in_valid  = 1'b0;
      ifc.in_real   = '0;
      ifc.in_imag   = '0;
      ifc.stop_flag = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  ifc.in_ready, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_done",      done, 0);
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_last",      ifc.last_symbol, 0);
      chk("rst_index",     ifc.special_index, 0);
      reset = 1'b0;
      @(negedge clk);

      run_basic("t1", 1, -1, 1'b0, 0);
      run_basic("t2", 3, -1, 1'b0, 0);
      run_basic("t3", 1, 30, 1'b0, 10);
      run_basic("t4", 1, -1, 1'b1, 0);

      // Zero-symbol packet: straight to DONE, no input accepted.
      got_q.delete();
      @(negedge clk);
      start       = 1'b1;
      num_symbols = '0;
      wait_done(da, dc, bc, rc);
      chk("t5_done_at",  da, 1);
      chk("t5_done_cnt", dc, 1);
      chk("t5_busy_cnt", bc, 0);
      chk("t5_rdy_cnt",  rc, 0);
      chk("t5_beats",    got_q.size(), 0);

      // Reset in the middle of symbol 2.
      got_q.delete();
      start_pkt(3);
      send(3, -1, 1'b0, 2, 40, rl, rb, ab);
      chk("t6_aborted", ab, 1);
      #5;
      reset = 1'b1;
      #1;
      chk("t6_in_ready",  ifc.in_ready, 0);
      chk("t6_busy",      busy, 0);
      chk("t6_done",      done, 0);
      chk("t6_out_valid", ifc.out_valid, 0);
      chk("t6_last",      ifc.last_symbol, 0);
      chk("t6_index",     ifc.special_index, 0);
      chk("t6_real",      ifc.out_real, 0);
      @(negedge clk);
      reset        = 1'b0;
      ifc.in_valid = 1'b0;
      wait_done(da, dc, bc, rc);
      chk("t6_no_done", dc, 0);
      chk("t6_no_busy", bc, 0);
      run_basic("t6b", 1, -1, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
